serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned subtractor that computes Diff = A - B and the final Borrow out, one bit per clock, LSB first.
- Datapath is a single full-subtractor cell plus a registered borrow; the cell is built from two instances of the team's half-subtractor module `subtractor`.
- Sits between operand-producing logic (start/operands) and result consumers (done/Diff/Borrow), trading latency for area against a parallel ripple chain.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when Diff/Borrow are updated.
- Diff  output  WIDTH  A - B mod 2^WIDTH; held until the next done.
- Borrow  output  1  final borrow out; 1 iff A < B (unsigned); held with Diff.

Behaviour:
- States: IDLE, RUN, DONE. Encoding: 2-bit.
- Reset (async assert, any state, including mid-RUN):
  - state=IDLE; busy=0; done=0; Diff=0; Borrow=0.
  - Internal shift registers, bit counter and borrow flop all cleared.
  - In-flight operation is discarded, never completed.
- IDLE:
  - busy=0.
  - If start=1 at an edge: load A into sa, B into sb, clear the borrow flop and count, go to RUN.
- RUN (busy=1):
  - Each edge: a0=sa[0], b0=sb[0], br=borrow flop.
  - d = a0^b0^br.
  - bo = (~a0&b0) | (~(a0^b0)&br).
  - Shift d into res MSB, shifting res right. Shift sa and sb right by one. borrow flop <= bo. count++.
  - start is ignored in RUN; A and B may change freely without effect.
- RUN exit:
  - On the edge where count reaches WIDTH-1 (the WIDTH-th bit edge), go to DONE.
  - On the same edge: Diff <= final res including this bit; Borrow <= bo; done <= 1.
- DONE:
  - busy=0; done=1 for exactly this cycle.
  - If start=1, accept exactly as in IDLE (load, go to RUN), giving back-to-back operation. Otherwise go to IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the accepting edge. Throughput is one operation per WIDTH+1 cycles.
- Diff and Borrow change only on the edge that raises done. They are stable throughout RUN and hold the previous result.
- Counter width: clog2(WIDTH); terminal compare against WIDTH-1, so there is no wrap for any WIDTH in range.
- Arithmetic is unsigned modulo 2^WIDTH. A=B gives Diff=0, Borrow=0.

Decomposition:
- Shared package sub_pkg (Verilog include sub_defs.vh) holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- Natural sub-module: full_subtractor (inputs A, B, Bin; outputs Diff, Bout), composed of two `subtractor` instances with Bout = Borrow1 | Borrow2.
- serial_subtractor instantiates one full_subtractor and contains only the FSM, shift registers, counter and output registers.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, start for 1 cycle from IDLE -> busy high for 8 cycles; done pulses once, 8 edges after accept; Diff=0x1E, Borrow=0.
- A=0x00, B=0x01 -> Diff=0xFF, Borrow=1. Then A=0xFF, B=0xFF -> Diff=0x00, Borrow=0. Diff must hold 0xFF during the entire second RUN.
- Start pulsed and operands changed at RUN cycles 2 and 5 -> both ignored; result matches the originally captured operands; exactly one done.
- Assert rst_n=0 asynchronously after the 4th RUN edge -> busy, done, Diff and Borrow read 0 immediately. After release, A=0x10, B=0x20 gives Diff=0xF0, Borrow=1.
- start held high continuously, operands stepped each acceptance -> accept occurs in each DONE cycle; done every 9 cycles; each result correct.
- WIDTH=4, all 256 A/B pairs -> Diff == (A-B)&0xF and Borrow == (A<B), checked against a scoreboard model.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor built from two half subtractors: A - B - Bin.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic d1;
  logic b1;
  logic b2;

  subtractor u_hs1 (
    .A      (A),
    .B      (B),
    .Diff   (d1),
    .Borrow (b1)
  );

  subtractor u_hs2 (
    .A      (d1),
    .B      (Bin),
    .Diff   (Diff),
    .Borrow (b2)
  );

  assign Bout = b1 | b2;

endmodule

// File: rtl/subtractor.sv
// Half subtractor: Diff = A - B for single bits, Borrow set when A=0 and B=1.
module subtractor (
  input  logic A,
  input  logic B,
  output logic Diff,
  output logic Borrow
);

  assign Diff   = A ^ B;
  assign Borrow = ~A & B;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, result after WIDTH edges.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             d_bit;
  logic             bo_bit;

  // Single full-subtractor cell operating on the current LSBs and registered borrow.
  full_subtractor u_fs (
    .A    (sa[0]),
    .B    (sb[0]),
    .Bin  (br),
    .Diff (d_bit),
    .Bout (bo_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand shift registers, partial result, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      res <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      sa  <= A;
      sb  <= B;
      br  <= 1'b0;
      cnt <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {d_bit, res[WIDTH-1:1]};
      br  <= bo_bit;
      // Hold on the final bit so the counter never wraps for power-of-two widths.
      if (!last) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Registered status and result outputs; result only changes on the finishing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= last;
      if (last) begin
        Diff   <= {d_bit, res[WIDTH-1:1]};
        Borrow <= bo_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    bit         perturb;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] held_d;
  logic       held_b;
  logic [7:0] ba [4];
  logic [7:0] bb [4];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .A      (a8),
    .B      (b8),
    .busy   (busy8),
    .done   (done8),
    .Diff   (diff8),
    .Borrow (borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .A      (a4),
    .B      (b4),
    .busy   (busy4),
    .done   (done4),
    .Diff   (diff4),
    .Borrow (borrow4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 operation from idle; checks busy and result hold during RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                     input logic eb, input logic [7:0] hd, input logic hb, input bit perturb);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      chk("busy_run", 32'(busy8), 32'd1);
      chk("diff_hold", 32'(diff8), 32'(hd));
      chk("borrow_hold", 32'(borrow8), 32'(hb));
      if (perturb && (n == 1 || n == 4)) begin
        start8 = 1'b1; a8 = ~a8; b8 = b8 + 8'h55;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    chk("latency8", 32'(n), 32'd8);
    chk("done8", 32'(done8), 32'd1);
    chk("busy_at_done", 32'(busy8), 32'd0);
    chk("diff8", 32'(diff8), 32'(ed));
    chk("borrow8", 32'(borrow8), 32'(eb));
    @(posedge clk); #1;
    chk("done_single", 32'(done8), 32'd0);
    chk("busy_after", 32'(busy8), 32'd0);
  endtask

  // One WIDTH=4 operation against the arithmetic model.
  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    int n;
    logic [3:0] ed;
    logic       eb;
    ed = a - b;
    eb = (a < b);
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency4", 32'(n), 32'd4);
    chk("diff4", 32'(diff4), 32'(ed));
    chk("borrow4", 32'(borrow4), 32'(eb));
  endtask

  initial begin
    int n;
    logic [7:0] ed;
    logic       eb;

    tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b1};
    tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    tbl[5] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    held_d = 8'h00;
    held_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, held_d, held_b, tbl[i].perturb);
      held_d = tbl[i].d;
      held_b = tbl[i].bo;
    end

    // Asynchronous reset after the fourth RUN edge discards the operation.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_diff", 32'(diff8), 32'd0);
    chk("arst_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h10, 8'h20, 8'hF0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Back-to-back: start held high, next operands accepted in each DONE cycle.
    ba[0] = 8'h5A; bb[0] = 8'h3C;
    ba[1] = 8'h00; bb[1] = 8'h01;
    ba[2] = 8'hC3; bb[2] = 8'h3C;
    ba[3] = 8'h01; bb[3] = 8'hFE;
    @(negedge clk);
    a8 = ba[0]; b8 = bb[0]; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = ba[1]; b8 = bb[1];
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!done8 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      ed = ba[k] - bb[k];
      eb = (ba[k] < bb[k]);
      chk("b2b_latency", 32'(n), 32'd8);
      chk("b2b_diff", 32'(diff8), 32'(ed));
      chk("b2b_borrow", 32'(borrow8), 32'(eb));
      if (k == 3) start8 = 1'b0;
      @(posedge clk); #1;
      if (k < 3) begin
        chk("b2b_accept", 32'(busy8), 32'd1);
        if (k < 2) begin
          a8 = ba[k+2]; b8 = bb[k+2];
        end
      end else begin
        chk("b2b_idle", 32'(busy8), 32'd0);
      end
    end

    // Exhaustive WIDTH=4 sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
